branch_update_tracker: RTL and testbench
========================================

# branch_update_tracker

Tracks in-flight predicted branches between fetch and resolution and drives the training side of the branch predictor. Records each branch PC and predicted direction in an in-order queue at prediction time. When the branch resolves, retires the oldest entry and issues a registered `update_en`/`update_val`/`update_pc` to the predictor. On a misprediction it flags the event, squashes all younger entries, and keeps accuracy counters for the performance harness.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥ 2
- `CNT_W`, 32: width of the statistics counters

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low (0 = reset); sampled on the rising edge of `clk`
- `pred_val`  in  1  fetch presents a predicted branch this cycle
- `pred_pc`  in  32  PC of that branch
- `pred_taken`  in  1  direction the predictor returned
- `pred_rdy`  out  1  tracker accepts a prediction this cycle
- `resolve_val`  in  1  execute resolves the oldest outstanding branch
- `resolve_taken`  in  1  actual direction
- `resolve_rdy`  out  1  an outstanding branch exists
- `update_en`  out  1  predictor write strobe (registered)
- `update_val`  out  1  actual outcome to train with
- `update_pc`  out  32  PC to index the predictor during the update cycle
- `mispredict`  out  1  one-cycle pulse, aligned with `update_en`
- `occupancy`  out  $clog2(DEPTH)+1  valid entries
- `num_branches`  out  `CNT_W`  resolved branches
- `num_mispred`  out  `CNT_W`  mispredicted branches

## Operation
- The queue entry is `{pc[31:0], pred_taken}`. Head and tail pointers are `$clog2(DEPTH)`+1 bits. Full/empty come from the wrap bit.
- Enqueue fires when `pred_val && pred_rdy`. Dequeue fires when `resolve_val && resolve_rdy`.
- `pred_rdy = !full && !update_en && state==RUN`. The predictor PC port is shared, so no prediction is accepted in an update cycle.
- `resolve_rdy = !empty`. `resolve_val` is ignored while `resolve_rdy=0`.
- On dequeue, the next cycle carries the following registered values:
  - `update_en=1`
  - `update_pc=head.pc`
  - `update_val=resolve_taken`
  - `mispredict=(head.pred_taken != resolve_taken)`
- Mispredicting dequeue:
  - All remaining entries are discarded (tail := new head, occupancy 0).
  - Any enqueue in that same cycle is dropped as wrong-path.
  - FSM moves RUN→RECOVER.
- FSM states:
  - RUN: normal operation.
  - RECOVER: lasts exactly one cycle (the update cycle); `pred_rdy=0`; then returns to RUN.
  - RECOVER→RUN is unconditional.
- Simultaneous enqueue and correct-prediction dequeue: both occur and occupancy is unchanged. With full+dequeue, enqueue is still refused because `pred_rdy` does not look at dequeue (no combinational ready path).
- Counters:
  - `num_branches` +1 per dequeue.
  - `num_mispred` +1 per mispredicting dequeue.
  - Both wrap modulo 2^`CNT_W`.
- Reset mid-operation discards all entries and any pending update. No `update_en` is issued for squashed or reset entries.

## Timing
- Reset values:
  - `update_en=0`, `update_val=0`, `update_pc=0`, `mispredict=0`
  - `occupancy=0`, both counters 0, state RUN
  - `pred_rdy=0` and `resolve_rdy=0` while `reset=0`
  - `pred_rdy=1` in the first cycle after `reset` returns to 1
- Prediction to `resolve_rdy`: 1 cycle (registered tail).
- Resolution to `update_en`/`mispredict`: 1 cycle. Counters reflect the resolution in the same cycle as `update_en`.
- After a correct resolution, `pred_rdy` drops for one cycle (the update cycle).
- After a misprediction, `pred_rdy` drops for one cycle (update and RECOVER coincide). It is high again 2 cycles after the resolving edge.
- `update_en` never asserts on two consecutive cycles unless resolutions occur on consecutive cycles. Each dequeue yields exactly one update.

## Structure
- Shared package `branch_pkg`: the state enum (`RUN`, `RECOVER`) and the `pred_entry_t` struct `{pc, pred_taken}`.
- One sub-module, `branch_pred_fifo`, holds the entry storage, pointers, occupancy and a `flush` input. Flush plus dequeue in the same cycle leaves the FIFO empty.
- The top level holds the FSM, output registers and counters.

## Test plan
- Reset held 3 cycles, then released:
  - during reset, all outputs are 0;
  - next cycle, `pred_rdy=1`, `resolve_rdy=0`, `occupancy=0`.
- Enqueue PCs 0x100 (taken), 0x104 (not taken), then resolve taken, not taken:
  - two `update_en` pulses with `update_pc` 0x100/`update_val=1` and 0x104/`update_val=0`;
  - `mispredict=0` on both;
  - `num_branches=2`, `num_mispred=0`.
- Enqueue 0x200 (taken), 0x204, 0x208, then resolve 0x200 not taken:
  - `mispredict=1` and `update_pc=0x200` next cycle;
  - `occupancy=0`;
  - `pred_rdy=0` for 1 cycle;
  - no updates ever for 0x204/0x208;
  - `num_mispred=1`.
- Fill 8 entries (`DEPTH=8`):
  - `pred_rdy=0` and `occupancy=8`;
  - a resolve plus `pred_val` in the same cycle dequeues only, giving `occupancy=7`;
  - pointers wrap correctly over 20 further enqueue/resolve pairs, with PCs checked in order.
- Mispredicting resolve while `pred_val=1` with PC 0x300 in the same cycle: 0x300 is not queued, `occupancy=0`.
- Assert `reset=0` with 4 entries queued and a resolve in flight: no `update_en` follows, and all counters and `occupancy` return to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types for the branch update tracker
package branch_pkg;

    localparam int PC_W = 32;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } track_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
    } pred_entry_t;

endpackage

// File: rtl/branch_pred_fifo.sv
// rtl/branch_pred_fifo.sv - in-order queue of predicted branches with flush
module branch_pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  pred_entry_t              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output pred_entry_t              head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    pred_entry_t   mem [DEPTH];
    logic [AW:0]   head;
    logic [AW:0]   tail;
    logic [AW:0]   head_next;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_comb begin
        empty     = (head == tail);
        full      = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
        occupancy = tail - head;
        head_data = mem[head[AW-1:0]];
        push_ok   = push && !full && !flush;
        pop_ok    = pop && !empty;
        head_next = pop_ok ? head + {{AW{1'b0}}, 1'b1} : head;
    end

    // Flush collapses the tail onto the (post-pop) head, dropping any push
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_next;
            if (flush) begin
                tail <= head_next;
            end else if (push_ok) begin
                tail <= tail + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage needs no reset; validity is defined by the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_update_tracker.sv
// rtl/branch_update_tracker.sv - tracks in-flight branches and trains the predictor
module branch_update_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_val,
    input  logic [31:0]              pred_pc,
    input  logic                     pred_taken,
    output logic                     pred_rdy,
    input  logic                     resolve_val,
    input  logic                     resolve_taken,
    output logic                     resolve_rdy,
    output logic                     update_en,
    output logic                     update_val,
    output logic [31:0]              update_pc,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         num_branches,
    output logic [CNT_W-1:0]         num_mispred
);

    track_state_t state;
    track_state_t state_next;
    pred_entry_t  head_data;
    pred_entry_t  push_data;
    logic         full;
    logic         empty;
    logic         enq;
    logic         deq;
    logic         mis;

    // Handshakes; the predictor PC port is busy during an update cycle
    always_comb begin
        pred_rdy  = reset && !full && !update_en && (state == RUN);
        resolve_rdy = reset && !empty;
        enq       = pred_val && pred_rdy;
        deq       = resolve_val && resolve_rdy;
        mis       = deq && (head_data.pred_taken != resolve_taken);
        push_data = '{pc: pred_pc, pred_taken: pred_taken};
    end

    branch_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (enq && !mis),
        .push_data (push_data),
        .pop       (deq),
        .flush     (mis),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a misprediction costs exactly one recovery cycle
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mis) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Registered predictor update and accuracy counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            update_en    <= 1'b0;
            update_val   <= 1'b0;
            update_pc    <= '0;
            mispredict   <= 1'b0;
            num_branches <= '0;
            num_mispred  <= '0;
        end else begin
            update_en  <= deq;
            mispredict <= mis;
            if (deq) begin
                update_pc    <= head_data.pc;
                update_val   <= resolve_taken;
                num_branches <= num_branches + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mis) begin
                num_mispred <= num_mispred + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_branch_update_tracker.sv
// tb/tb_branch_update_tracker.sv - directed scoreboard bench for branch_update_tracker
module tb_branch_update_tracker;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic        t;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic        val;
        logic        mis;
    } upd_t;

    logic                     clk;
    logic                     reset;
    logic                     pred_val;
    logic [31:0]              pred_pc;
    logic                     pred_taken;
    logic                     pred_rdy;
    logic                     resolve_val;
    logic                     resolve_taken;
    logic                     resolve_rdy;
    logic                     update_en;
    logic                     update_val;
    logic [31:0]              update_pc;
    logic                     mispredict;
    logic [$clog2(DEPTH):0]   occupancy;
    logic [CNT_W-1:0]         num_branches;
    logic [CNT_W-1:0]         num_mispred;

    int   checks;
    int   errors;
    ent_t mq[$];
    upd_t eq[$];
    logic model_upd;
    int   m_br;
    int   m_mis;

    branch_update_tracker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_val      (pred_val),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_rdy      (pred_rdy),
        .resolve_val   (resolve_val),
        .resolve_taken (resolve_taken),
        .resolve_rdy   (resolve_rdy),
        .update_en     (update_en),
        .update_val    (update_val),
        .update_pc     (update_pc),
        .mispredict    (mispredict),
        .occupancy     (occupancy),
        .num_branches  (num_branches),
        .num_mispred   (num_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_update_en"}, update_en, 0);
        check({tag, "_update_val"}, update_val, 0);
        check({tag, "_update_pc"}, update_pc, 0);
        check({tag, "_mispredict"}, mispredict, 0);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_num_branches"}, num_branches, 0);
        check({tag, "_num_mispred"}, num_mispred, 0);
        check({tag, "_pred_rdy"}, pred_rdy, 0);
        check({tag, "_resolve_rdy"}, resolve_rdy, 0);
    endtask

    // One clock step: drive inputs, predict with the model, compare after the edge
    task automatic drive(input logic pv, input logic [31:0] pc, input logic pt,
                         input logic rv, input logic rt);
        logic exp_prdy;
        logic acc_r;
        logic mis;
        logic acc_p;
        upd_t u;
        ent_t e;
        upd_t got;
        pred_val      = pv;
        pred_pc       = pc;
        pred_taken    = pt;
        resolve_val   = rv;
        resolve_taken = rt;
        #1;
        exp_prdy = (mq.size() < DEPTH) && !model_upd;
        check("pred_rdy", pred_rdy, exp_prdy);
        check("resolve_rdy", resolve_rdy, mq.size() != 0);
        acc_r = rv && (mq.size() != 0);
        mis   = 1'b0;
        if (acc_r) mis = (mq[0].t != rt);
        acc_p = pv && exp_prdy && !mis;
        if (acc_r) begin
            u.pc  = mq[0].pc;
            u.val = rt;
            u.mis = mis;
            eq.push_back(u);
            void'(mq.pop_front());
            m_br++;
            if (mis) begin
                m_mis++;
                mq.delete();
            end
        end
        if (acc_p) begin
            e.pc = pc;
            e.t  = pt;
            mq.push_back(e);
        end
        model_upd = acc_r;
        @(posedge clk);
        @(negedge clk);
        pred_val    = 1'b0;
        resolve_val = 1'b0;
        if (update_en === 1'b1) begin
            if (eq.size() == 0) begin
                check("unexpected_update_pc", update_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                got = eq.pop_front();
                check("update_pc", update_pc, got.pc);
                check("update_val", update_val, got.val);
                check("mispredict", mispredict, got.mis);
            end
        end else begin
            check("update_en", update_en, eq.size() != 0);
            eq.delete();
        end
        check("occupancy", occupancy, mq.size());
        check("num_branches", num_branches, m_br);
        check("num_mispred", num_mispred, m_mis);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic rt;
        checks        = 0;
        errors        = 0;
        model_upd     = 1'b0;
        m_br          = 0;
        m_mis         = 0;
        reset         = 1'b0;
        pred_val      = 1'b0;
        pred_pc       = '0;
        pred_taken    = 1'b0;
        resolve_val   = 1'b0;
        resolve_taken = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs_zero("reset");
        end
        reset = 1'b1;
        #1;
        check("post_reset_pred_rdy", pred_rdy, 1);
        check("post_reset_resolve_rdy", resolve_rdy, 0);
        check("post_reset_occupancy", occupancy, 0);

        // Two correct resolutions, back to back
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("update_pc_0x100", update_pc, 32'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("update_pc_0x104", update_pc, 32'h104);
        check("two_branches", num_branches, 2);
        check("zero_mispred", num_mispred, 0);
        idle();

        // Misprediction squashes younger entries
        drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h208, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("mis_pulse", mispredict, 1);
        check("mis_pc", update_pc, 32'h200);
        check("mis_occ", occupancy, 0);
        check("mis_recover_prdy", pred_rdy, 0);
        check("mis_count", num_mispred, 1);
        idle();
        check("mis_prdy_back", pred_rdy, 1);
        idle();

        // Fill to DEPTH, then dequeue while full
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 4), 1'(i % 2), 1'b0, 1'b0);
        end
        check("full_occ", occupancy, DEPTH);
        check("full_prdy", pred_rdy, 0);
        drive(1'b1, 32'h5FC, 1'b0, 1'b1, mq[0].t);
        check("full_deq_occ", occupancy, DEPTH - 1);

        // Twenty enqueue/resolve pairs through the wrap point
        for (int i = 0; i < 20; i++) begin
            idle();
            rt = mq[0].t;
            drive(1'b1, 32'h2000 + 32'(i * 4), 1'($urandom_range(0, 1)), 1'b1, rt);
        end
        check("wrap_occ", occupancy, DEPTH - 1);
        while (mq.size() != 0) begin
            rt = mq[0].t;
            drive(1'b0, 32'h0, 1'b0, 1'b1, rt);
        end
        idle();

        // Mispredict with a wrong-path prediction in the same cycle
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        check("wrongpath_occ", occupancy, 0);
        idle();
        check("wrongpath_resolve_rdy", resolve_rdy, 0);

        // Reset in the middle of operation with a resolve in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h500 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        end
        check("pre_reset_occ", occupancy, 4);
        reset         = 1'b0;
        resolve_val   = 1'b1;
        resolve_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resolve_val = 1'b0;
        check_outputs_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        check("midreset_no_update", update_en, 0);
        mq.delete();
        eq.delete();
        model_upd = 1'b0;
        m_br      = 0;
        m_mis     = 0;
        reset     = 1'b1;
        idle();
        drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
